// File: rtl/shift_seq_counter.sv
`default_nettype none
// ============================================================================
//  Module   : shift_seq_counter
//  Purpose  : WIDTH-bit shift-register sequence source stepping in ring,
//             Johnson or Fibonacci-LFSR mode, with parallel load, illegal
//             state recovery to SEED, a seed-return pulse and a measured
//             seed-to-seed period.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module shift_seq_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1100)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err,
    output logic [WIDTH:0]   period,
    output logic             period_vld
);

    localparam int         c_CNT_W   = WIDTH + 1;
    localparam logic [1:0] c_RING    = 2'b00;
    localparam logic [1:0] c_JOHNSON = 2'b01;
    localparam logic [1:0] c_LFSR    = 2'b10;
    localparam logic [1:0] c_HOLD    = 2'b11;

    logic [WIDTH-1:0]   r_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] r_period;
    logic [1:0]         r_mode;
    logic               r_wrap;
    logic               r_err;
    logic               r_vld;

    logic [WIDTH-1:0]   w_next;
    logic               w_legal;
    logic               w_step;
    logic               w_mode_chg;
    logic [4:0]         w_ones;
    logic [4:0]         w_trans;
    logic [c_CNT_W-1:0] w_cnt_base;
    logic [c_CNT_W-1:0] w_cnt_inc;

    // Next state, legality of the current state and the saturating step count
    always_comb begin
        w_next     = r_q;
        w_legal    = 1'b1;
        w_ones     = '0;
        w_trans    = '0;
        w_step     = en && (mode != c_HOLD);
        w_mode_chg = (mode != r_mode);

        // Johnson states have at most one edge between adjacent bits
        for (int i = 0; i < WIDTH; i++) begin
            w_ones = w_ones + 5'(r_q[i]);
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            w_trans = w_trans + 5'(r_q[i] ^ r_q[i+1]);
        end

        case (mode)
            c_RING: begin
                w_next  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_legal = (w_ones == 5'd1);
            end
            c_JOHNSON: begin
                w_next  = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
                w_legal = (w_trans <= 5'd1);
            end
            c_LFSR: begin
                w_next  = {r_q[WIDTH-2:0], ^(r_q & TAPS)};
                w_legal = (r_q != '0);
            end
            default: begin
                w_next  = r_q;
                w_legal = 1'b1;
            end
        endcase

        // A mode change restarts the measurement with this step counted as 1
        w_cnt_base = w_mode_chg ? '0 : r_cnt;
        w_cnt_inc  = (w_cnt_base == {c_CNT_W{1'b1}}) ? w_cnt_base
                                                     : w_cnt_base + 1'b1;
    end

    // State register, pulses and period measurement
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= SEED;
            r_cnt    <= '0;
            r_period <= '0;
            r_mode   <= c_RING;
            r_wrap   <= 1'b0;
            r_err    <= 1'b0;
            r_vld    <= 1'b0;
        end else if (load) begin
            // Loaded value is checked only when it is next stepped
            r_q    <= load_val;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
            r_vld  <= 1'b0;
        end else if (w_step) begin
            r_mode <= mode;
            if (!w_legal) begin
                r_q    <= SEED;
                r_err  <= 1'b1;
                r_wrap <= 1'b0;
                r_cnt  <= '0;
                if (w_mode_chg) begin
                    r_vld <= 1'b0;
                end
            end else begin
                r_q   <= w_next;
                r_err <= 1'b0;
                if (w_next == SEED) begin
                    r_wrap   <= 1'b1;
                    r_period <= w_cnt_inc;
                    r_vld    <= 1'b1;
                    r_cnt    <= '0;
                end else begin
                    r_wrap <= 1'b0;
                    r_cnt  <= w_cnt_inc;
                    if (w_mode_chg) begin
                        r_vld <= 1'b0;
                    end
                end
            end
        end else begin
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end
    end

    assign q          = r_q;
    assign wrap       = r_wrap;
    assign err        = r_err;
    assign period     = r_period;
    assign period_vld = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_seq_counter
//  Purpose  : Directed vector bench for shift_seq_counter (WIDTH=4 defaults).
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_seq_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic [1:0] mode;
    logic [3:0] q;
    logic       wrap;
    logic       err;
    logic [4:0] period;
    logic       period_vld;

    int total;
    int bad;

    typedef struct {
        logic       r;
        logic       l;
        logic [3:0] lv;
        logic       e;
        logic [1:0] m;
        logic [3:0] q;
        logic       w;
        logic       er;
        logic [4:0] p;
        logic       pv;
    } vec_t;

    vec_t vecs[$];

    shift_seq_counter dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .load_val   (load_val),
        .mode       (mode),
        .q          (q),
        .wrap       (wrap),
        .err        (err),
        .period     (period),
        .period_vld (period_vld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input logic r, input logic l, input logic [3:0] lv,
                       input logic e, input logic [1:0] m, input logic [3:0] eq,
                       input logic ew, input logic eer, input logic [4:0] ep,
                       input logic epv);
        vec_t v;
        v.r = r; v.l = l; v.lv = lv; v.e = e; v.m = m;
        v.q = eq; v.w = ew; v.er = eer; v.p = ep; v.pv = epv;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, clock it, compare all outputs 1 ns later
    task automatic apply(input string name, input logic r, input logic l,
                         input logic [3:0] lv, input logic e, input logic [1:0] m,
                         input logic [3:0] eq, input logic ew, input logic eer,
                         input logic [4:0] ep, input logic epv);
        rst = r; load = l; load_val = lv; en = e; mode = m;
        @(posedge clk);
        #1;
        total++;
        if ({q, wrap, err, period, period_vld} !== {eq, ew, eer, ep, epv}) begin
            bad++;
            $display("FAIL %s: got q=%h wrap=%b err=%b period=%0d vld=%b, want q=%h wrap=%b err=%b period=%0d vld=%b",
                     name, q, wrap, err, period, period_vld, eq, ew, eer, ep, epv);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 4'h0; mode = 2'b00;

        // Ring: rst then eight steps
        add(1,0,0,0,0, 4'h1,0,0,0,0);
        add(0,0,0,1,0, 4'h2,0,0,0,0);
        add(0,0,0,1,0, 4'h4,0,0,0,0);
        add(0,0,0,1,0, 4'h8,0,0,0,0);
        add(0,0,0,1,0, 4'h1,1,0,4,1);
        add(0,0,0,1,0, 4'h2,0,0,4,1);
        add(0,0,0,1,0, 4'h4,0,0,4,1);
        add(0,0,0,1,0, 4'h8,0,0,4,1);
        add(0,0,0,1,0, 4'h1,1,0,4,1);
        // Johnson
        add(1,0,0,0,1, 4'h1,0,0,0,0);
        add(0,0,0,1,1, 4'h3,0,0,0,0);
        add(0,0,0,1,1, 4'h7,0,0,0,0);
        add(0,0,0,1,1, 4'hF,0,0,0,0);
        add(0,0,0,1,1, 4'hE,0,0,0,0);
        add(0,0,0,1,1, 4'hC,0,0,0,0);
        add(0,0,0,1,1, 4'h8,0,0,0,0);
        add(0,0,0,1,1, 4'h0,0,0,0,0);
        add(0,0,0,1,1, 4'h1,1,0,8,1);
        // LFSR x^4+x^3+1
        add(1,0,0,0,2, 4'h1,0,0,0,0);
        add(0,0,0,1,2, 4'h2,0,0,0,0);
        add(0,0,0,1,2, 4'h4,0,0,0,0);
        add(0,0,0,1,2, 4'h9,0,0,0,0);
        add(0,0,0,1,2, 4'h3,0,0,0,0);
        add(0,0,0,1,2, 4'h6,0,0,0,0);
        add(0,0,0,1,2, 4'hD,0,0,0,0);
        add(0,0,0,1,2, 4'hA,0,0,0,0);
        add(0,0,0,1,2, 4'h5,0,0,0,0);
        add(0,0,0,1,2, 4'hB,0,0,0,0);
        add(0,0,0,1,2, 4'h7,0,0,0,0);
        add(0,0,0,1,2, 4'hF,0,0,0,0);
        add(0,0,0,1,2, 4'hE,0,0,0,0);
        add(0,0,0,1,2, 4'hC,0,0,0,0);
        add(0,0,0,1,2, 4'h8,0,0,0,0);
        add(0,0,0,1,2, 4'h1,1,0,15,1);
        // Recovery: LFSR from 0000, then ring from 0110
        add(0,1,4'h0,0,2, 4'h0,0,0,15,0);
        add(0,0,0,1,2, 4'h1,0,1,15,0);
        add(0,0,0,1,2, 4'h2,0,0,15,0);
        add(0,1,4'h6,0,0, 4'h6,0,0,15,0);
        add(0,0,0,1,0, 4'h1,0,1,15,0);
        add(0,0,0,0,0, 4'h1,0,0,15,0);

        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i].r, vecs[i].l, vecs[i].lv,
                  vecs[i].e, vecs[i].m, vecs[i].q, vecs[i].w, vecs[i].er,
                  vecs[i].p, vecs[i].pv);
        end

        // Control priorities
        apply("ctl_rst",     1,0,4'h0,0,0, 4'h1,0,0,0,0);
        apply("ctl_step",    0,0,4'h0,1,0, 4'h2,0,0,0,0);
        apply("ctl_load_en", 0,1,4'h5,1,0, 4'h5,0,0,0,0);
        apply("ctl_illegal", 0,0,4'h0,1,0, 4'h1,0,1,0,0);
        apply("ctl_step2",   0,0,4'h0,1,0, 4'h2,0,0,0,0);
        apply("ctl_en_low",  0,0,4'h0,0,0, 4'h2,0,0,0,0);
        apply("ctl_mode11",  0,0,4'h0,1,3, 4'h2,0,0,0,0);
        apply("ctl_resume",  0,0,4'h0,1,0, 4'h4,0,0,0,0);
        apply("ctl_rst_ld",  1,1,4'h8,1,0, 4'h1,0,0,0,0);

        // Mode switch: ring wrap, three more ring steps, then Johnson
        for (int i = 0; i < 4; i++) begin
            rst = 0; load = 0; en = 1; mode = 2'b00;
            @(posedge clk);
        end
        #1;
        apply("sw_ring1",   0,0,4'h0,1,0, 4'h2,0,0,4,1);
        apply("sw_ring2",   0,0,4'h0,1,0, 4'h4,0,0,4,1);
        apply("sw_ring3",   0,0,4'h0,1,0, 4'h8,0,0,4,1);
        apply("sw_to_john", 0,0,4'h0,1,1, 4'h0,0,0,4,0);
        apply("sw_john_wr", 0,0,4'h0,1,1, 4'h1,1,0,2,1);

        // LFSR never visits zero over a full period
        apply("lfsr_rst", 1,0,4'h0,0,2, 4'h1,0,0,0,0);
        rst = 0; en = 1; mode = 2'b10;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (q === 4'h0 || err !== 1'b0) begin
                bad++;
                $display("FAIL lfsr_nonzero%0d: got q=%h err=%b, want q!=0 err=0", i, q, err);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
